wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 95 +++++++++
 tb/tb_wb_regfile.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback register file with per-register pending-write scoreboard.
// 32 x 32-bit registers, same-cycle writeback bypass on both read ports,
// and saturating pending counters that drive operand-busy and stall outputs.
module wb_regfile #(
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_wdata,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic        flush,
  input  logic        re1,
  input  logic        re2,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        rbusy1,
  output logic        rbusy2,
  output logic        stall_req
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [31:0]       regs [32];
  logic [PEND_W-1:0] pend [32];

  logic [31:0]       ret_vec;
  logic [31:0]       inc_vec;
  logic [PEND_W-1:0] p1, p2, p_iss;
  logic              iss_full;
  logic              acc;

  // Per-register retire and accepted-issue strobes for this cycle.
  always_comb begin
    ret_vec = '0;
    inc_vec = '0;
    for (int r = 1; r < 32; r++) begin
      ret_vec[r] = wb_wreg && (wb_rd == 5'(r));
      inc_vec[r] = acc && (iss_rd == 5'(r));
    end
  end

  // Read ports: x0 and disabled ports read zero; writeback data bypasses storage.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (re1 && raddr1 != 5'd0)
      rdata1 = (wb_wreg && wb_rd == raddr1) ? wb_wdata : regs[raddr1];
    if (re2 && raddr2 != 5'd0)
      rdata2 = (wb_wreg && wb_rd == raddr2) ? wb_wdata : regs[raddr2];
  end

  // Busy if reservations remain after counting a retire happening right now.
  always_comb begin
    p1     = pend[raddr1];
    p2     = pend[raddr2];
    p_iss  = pend[iss_rd];
    rbusy1 = re1 && (raddr1 != 5'd0) && (p1 != '0) &&
             !((p1 == PEND_ONE) && ret_vec[raddr1]);
    rbusy2 = re2 && (raddr2 != 5'd0) && (p2 != '0) &&
             !((p2 == PEND_ONE) && ret_vec[raddr2]);
    // A saturated counter can only take a new issue if a retire frees a slot.
    iss_full  = iss_valid && (iss_rd != 5'd0) && (p_iss == PEND_MAX) &&
                !ret_vec[iss_rd];
    stall_req = rbusy1 | rbusy2 | iss_full;
    acc       = iss_valid && !stall_req && !flush && (iss_rd != 5'd0);
  end

  // Storage write and pending-counter update; flush clears counters but not data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
    end else begin
      if (wb_wreg && wb_rd != 5'd0)
        regs[wb_rd] <= wb_wdata;
      for (int r = 0; r < 32; r++) begin
        if (flush)
          pend[r] <= '0;
        else if (inc_vec[r] && !ret_vec[r])
          pend[r] <= pend[r] + PEND_ONE;
        else if (!inc_vec[r] && ret_vec[r] && pend[r] != '0)
          pend[r] <= pend[r] - PEND_ONE;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected outputs for the
// current cycle; a monitor on the falling edge pops and compares them.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        flush;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        rbusy1, rbusy2, stall_req;

  wb_regfile #(.PEND_W(2)) dut (
    .clk(clk), .rst(rst), .wb_wreg(wb_wreg), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .rbusy1(rbusy1), .rbusy2(rbusy2),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
    logic        st;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // Monitor: compare queued expectations against outputs mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (rdata1 !== e.d1 || rbusy1 !== e.b1 || rdata2 !== e.d2 ||
          rbusy2 !== e.b2 || stall_req !== e.st) begin
        failed++;
        $display("FAIL %s: got d1=%h b1=%b d2=%h b2=%b st=%b, want d1=%h b1=%b d2=%h b2=%b st=%b",
                 e.name, rdata1, rbusy1, rdata2, rbusy2, stall_req,
                 e.d1, e.b1, e.d2, e.b2, e.st);
      end
    end
  end

  task automatic idle();
    rst = 1'b1; wb_wreg = 1'b0; wb_rd = '0; wb_wdata = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_out(input string name, input logic [31:0] d1, input logic b1,
                            input logic [31:0] d2, input logic b2, input logic st);
    exp_t e;
    e.name = name; e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_wreg = 1'b1; wb_rd = rd; wb_wdata = d;
  endtask

  task automatic iss(input logic [4:0] rd);
    iss_valid = 1'b1; iss_rd = rd;
  endtask

  task automatic rd1(input logic [4:0] a);
    re1 = 1'b1; raddr1 = a;
  endtask

  task automatic rd2(input logic [4:0] a);
    re2 = 1'b1; raddr2 = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle();

    // Reset state
    expect_out("reset_idle", 0, 0, 0, 0, 0);
    tick();
    rd1(5'd5); rd2(5'd31);
    expect_out("reset_regs_zero", 0, 0, 0, 0, 0);
    tick();

    // Issue / bypass / storage read
    iss(5'd5);
    expect_out("iss5_accept", 0, 0, 0, 0, 0);
    tick();
    rd1(5'd5);
    expect_out("r5_busy", 0, 1, 0, 0, 1);
    tick();
    rd1(5'd5); wb(5'd5, 32'hDEADBEEF);
    expect_out("r5_bypass", 32'hDEADBEEF, 0, 0, 0, 0);
    tick();
    rd1(5'd5);
    expect_out("r5_storage", 32'hDEADBEEF, 0, 0, 0, 0);
    tick();
    raddr1 = 5'd5;
    expect_out("r5_re_off", 0, 0, 0, 0, 0);
    tick();

    // Counter saturation
    for (int i = 0; i < 3; i++) begin
      iss(5'd7);
      expect_out($sformatf("iss7_%0d", i), 0, 0, 0, 0, 0);
      tick();
    end
    iss(5'd7);
    expect_out("iss7_full_stall", 0, 0, 0, 0, 1);
    tick();
    iss(5'd7); wb(5'd7, 32'h77);
    expect_out("iss7_full_with_ret", 0, 0, 0, 0, 0);
    tick();
    rd2(5'd7); wb(5'd7, 32'h70);
    expect_out("r7_ret_cnt3", 0, 0, 32'h70, 1, 1);
    tick();
    rd2(5'd7); wb(5'd7, 32'h71);
    expect_out("r7_ret_cnt2", 0, 0, 32'h71, 1, 1);
    tick();
    rd2(5'd7); wb(5'd7, 32'h72);
    expect_out("r7_ret_cnt1", 0, 0, 32'h72, 0, 0);
    tick();
    rd2(5'd7);
    expect_out("r7_drained", 0, 0, 32'h72, 0, 0);
    tick();

    // x0 behaviour
    wb(5'd0, 32'h1234); iss(5'd0); rd1(5'd0); rd2(5'd0);
    expect_out("x0_write_issue", 0, 0, 0, 0, 0);
    tick();
    rd1(5'd0); rd2(5'd0);
    expect_out("x0_read", 0, 0, 0, 0, 0);
    tick();

    // Flush with concurrent writeback and dropped issue
    iss(5'd3);
    expect_out("iss3", 0, 0, 0, 0, 0);
    tick();
    iss(5'd9);
    expect_out("iss9", 0, 0, 0, 0, 0);
    tick();
    flush = 1'b1; wb(5'd3, 32'h55); iss(5'd11); rd1(5'd3); rd2(5'd9);
    expect_out("flush_cycle", 32'h55, 0, 0, 1, 1);
    tick();
    rd1(5'd3); rd2(5'd9);
    expect_out("after_flush", 32'h55, 0, 0, 0, 0);
    tick();
    rd1(5'd11);
    expect_out("flush_drop_iss11", 0, 0, 0, 0, 0);
    tick();

    // Reset mid-operation
    iss(5'd4);
    expect_out("iss4", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0; wb(5'd4, 32'hAB); iss(5'd4);
    tick();
    rd1(5'd4); rd2(5'd5);
    expect_out("after_rst_r4_r5", 0, 0, 0, 0, 0);
    tick();
    rd1(5'd3); rd2(5'd7);
    expect_out("after_rst_r3_r7", 0, 0, 0, 0, 0);
    tick();

    // Retire with no reservation must not underflow
    wb(5'd6, 32'h66); rd1(5'd6);
    expect_out("wb6_no_pend", 32'h66, 0, 0, 0, 0);
    tick();
    rd1(5'd6); iss(5'd8);
    expect_out("r6_storage", 32'h66, 0, 0, 0, 0);
    tick();
    iss(5'd6);
    expect_out("iss6", 0, 0, 0, 0, 0);
    tick();
    rd1(5'd6);
    expect_out("r6_cnt1", 32'h66, 1, 0, 0, 1);
    tick();
    rd1(5'd6); rd2(5'd8); wb(5'd6, 32'h67);
    expect_out("r6_ret_r8_busy", 32'h67, 0, 0, 1, 1);
    tick();

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
